ysyx_23060111_rf_sb: RTL and testbench
======================================

# ysyx_23060111_rf_sb

Parametrised general-purpose register file with an integrated write-pending scoreboard. It serves the NPC decode/writeback path. The register file provides two asynchronous read ports and one synchronous write port with register 0 hardwired to zero. It also tracks which destination registers have an issued-but-not-written-back result, so decode can stall on RAW/WAW hazards. An optional write-to-read bypass can be compiled in.

## Interface
Parameters:
- ADDR_WIDTH, default 5: register index width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, default 32: register data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- wen  in  1  writeback valid.
- waddr  in  ADDR_WIDTH  writeback destination index.
- wdata  in  DATA_WIDTH  writeback data.
- iss_en  in  1  issue valid; marks iss_addr pending.
- iss_addr  in  ADDR_WIDTH  destination index of the issuing instruction.
- iss_busy  out  1  combinational: pending bit of iss_addr, used for the WAW check.
- raddr1, raddr2  in  ADDR_WIDTH  read indices.
- rdata1, rdata2  out  DATA_WIDTH  combinational read data.
- rbusy1, rbusy2  out  1  combinational: pending bit for raddr1/raddr2.
- busy_cnt  out  ADDR_WIDTH+1  registered count of pending registers.

## Operation
- State: data array rf[2**ADDR_WIDTH] and pending bits pend[2**ADDR_WIDTH].
- Reset (rst_n=0 at edge):
  - All rf entries and pend bits are set to 0, and busy_cnt is set to 0.
  - wen and iss_en are ignored in that cycle.
- Write: on an edge with wen=1 and waddr!=0, rf[waddr] takes wdata.
  - The same edge clears pend[waddr], unless that clear is overridden by a set (see below).
- Issue: on an edge with iss_en=1 and iss_addr!=0, pend[iss_addr] is set to 1.
- Index 0:
  - rf[0] always reads 0.
  - pend[0] is always 0; iss_busy, rbusy1 and rbusy2 are 0 for index 0.
  - Writes and issues to index 0 are dropped.
- Simultaneous issue and writeback to the same nonzero index: the set wins and pend stays 1, since the newer instruction owns the register.
  - rf is still written with wdata.
- Issue to an already-pending index is legal but creates a WAW hazard.
  - pend stays 1; the first writeback clears it.
  - Decode must stall while iss_busy=1. The block does not detect or flag the hazard.
- Writeback to a non-pending index writes rf normally; pend stays 0.
- busy_cnt always equals the population count of pend. Each edge, let s = effective new set (a 0→1 transition) and c = effective clear (a 1→0 transition); then busy_cnt_next = busy_cnt + s - c.
- busy_cnt maximum is 2**ADDR_WIDTH - 1, so it never wraps.
- Reads are purely combinational from rf/pend (post-edge state), apart from the bypass described under Configuration.

## Timing
- Read latency is 0 cycles (combinational).
- A write is visible on rdata at the first read after the write edge.
- A pend set is visible on rbusy/iss_busy the cycle after the issue edge.
- A pend clear is visible the cycle after the writeback edge (no bypass), or in the same cycle (bypass, see Configuration).
- busy_cnt updates on the same edge as pend.
- Reset asserted mid-operation overrides any concurrent wen/iss_en in that cycle. Outputs show reset values from the next cycle onward.

## Configuration
- Macro YSYX_23060111_RF_BYPASS_EN.
- When defined, a read port n with wen=1, waddr!=0 and raddrn==waddr in the current cycle gives:
  - rdata_n = wdata;
  - rbusy_n = 0;
  - iss_busy likewise reads 0 when iss_addr==waddr under the same conditions.
- When undefined, reads return the stored rf/pend only, so a same-cycle writeback is seen one cycle later.
- busy_cnt is unaffected by the macro.

## Test plan
Defaults ADDR_WIDTH=5, DATA_WIDTH=32 unless stated.
- Reset: preload junk, hold rst_n=0 for one edge → every rdata=0, every rbusy=0, busy_cnt=0. A wen=1 applied in the reset cycle is dropped.
- Issue then writeback: issue x5 → next cycle rbusy1(raddr1=5)=1 and busy_cnt=1. Then wen x5 with 0xDEADBEEF →
  - next cycle: rdata1=0xDEADBEEF, rbusy1=0, busy_cnt=0;
  - with BYPASS_EN, rdata1=0xDEADBEEF and rbusy1=0 already in the wen cycle.
- x0: wen x0 with 0x12345678 plus iss_en x0 → rdata(0)=0, rbusy=0, iss_busy=0, busy_cnt unchanged.
- Same-index collision: x7 pending; iss_en x7 and wen x7 (0xA5A5A5A5) on the same edge → rf[7]=0xA5A5A5A5, pend[7]=1, busy_cnt unchanged.
- Different-index collision: x3 pending; same edge issue x9 and writeback x3 → pend[3]=0, pend[9]=1, busy_cnt unchanged.
- Fill: issue x1..x31 on consecutive cycles → busy_cnt=31 with no wrap. Then writeback all 31 → busy_cnt=0. Repeat with ADDR_WIDTH=4 → peak busy_cnt=15.

Source files
------------

// File: rtl/ysyx_23060111_rf_sb.sv
// ysyx_23060111_rf_sb
// General-purpose register file with an integrated write-pending scoreboard
// for the NPC decode/writeback path. Two combinational read ports, one
// synchronous write port, register 0 hardwired to zero. A pending bit per
// register marks issued-but-not-written-back destinations so decode can
// stall on RAW/WAW hazards.
//
// Optional feature: define YSYX_23060111_RF_BYPASS_EN to forward a
// same-cycle writeback onto the read ports (data and pending state).
//
// Ports:
//   clk                    clock, all state updates on the rising edge
//   rst_n                  synchronous active-low reset
//   wen / waddr / wdata    writeback port
//   iss_en / iss_addr      issue port, marks iss_addr pending
//   iss_busy               pending bit of iss_addr (WAW check)
//   raddr1 / raddr2        read indices
//   rdata1 / rdata2        combinational read data
//   rbusy1 / rbusy2        pending bits of raddr1 / raddr2
//   busy_cnt               registered number of pending registers
module ysyx_23060111_rf_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  iss_en,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    output logic                  iss_busy,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    output logic [ADDR_WIDTH:0]   busy_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [ADDR_WIDTH:0]   cnt;

    logic wr_ok;
    logic iss_ok;
    logic set_eff;
    logic clr_eff;

    // Accesses to index 0 are dropped, so pend[0] and rf[0] are never touched.
    assign wr_ok  = wen && (waddr != '0);
    assign iss_ok = iss_en && (iss_addr != '0);

    // Only real 0->1 and 1->0 transitions move the counter. A clear of the
    // register being re-issued on the same edge is cancelled because the
    // newer instruction owns the register.
    assign set_eff = iss_ok && !pend[iss_addr];
    assign clr_eff = wr_ok && pend[waddr] && !(iss_ok && (iss_addr == waddr));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
            pend <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) begin
                rf[waddr]   <= wdata;
                pend[waddr] <= 1'b0;
            end
            // Placed after the clear so a same-index issue overrides it.
            if (iss_ok) begin
                pend[iss_addr] <= 1'b1;
            end
            cnt <= cnt + {{ADDR_WIDTH{1'b0}}, set_eff} - {{ADDR_WIDTH{1'b0}}, clr_eff};
        end
    end

    always_comb begin
        rdata1   = (raddr1 == '0) ? '0 : rf[raddr1];
        rdata2   = (raddr2 == '0) ? '0 : rf[raddr2];
        rbusy1   = pend[raddr1];
        rbusy2   = pend[raddr2];
        iss_busy = pend[iss_addr];
`ifdef YSYX_23060111_RF_BYPASS_EN
        // A writeback landing this cycle is already the architectural value.
        if (wr_ok && (raddr1 == waddr)) begin
            rdata1 = wdata;
            rbusy1 = 1'b0;
        end
        if (wr_ok && (raddr2 == waddr)) begin
            rdata2 = wdata;
            rbusy2 = 1'b0;
        end
        if (wr_ok && (iss_addr == waddr)) begin
            iss_busy = 1'b0;
        end
`endif
    end

    assign busy_cnt = cnt;

endmodule

// File: tb/tb_ysyx_23060111_rf_sb.sv
// Self-checking bench for ysyx_23060111_rf_sb. A behavioural model (plain
// arrays, popcount) is compared with the main instance every negedge once
// the model has seen a reset; directed sequences add literal expectations.
// A second instance with ADDR_WIDTH=4 covers the smaller fill peak.
module tb_ysyx_23060111_rf_sb;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_busy;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        rbusy1;
    logic        rbusy2;
    logic [5:0]  busy_cnt;

    logic        n4_rst_n;
    logic        n4_wen;
    logic [3:0]  n4_waddr;
    logic [7:0]  n4_wdata;
    logic        n4_iss_en;
    logic [3:0]  n4_iss_addr;
    logic        n4_iss_busy;
    logic [3:0]  n4_raddr1;
    logic [3:0]  n4_raddr2;
    logic [7:0]  n4_rdata1;
    logic [7:0]  n4_rdata2;
    logic        n4_rbusy1;
    logic        n4_rbusy2;
    logic [4:0]  n4_busy_cnt;

    int checks   = 0;
    int failures = 0;

    ysyx_23060111_rf_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_busy(iss_busy),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .busy_cnt(busy_cnt)
    );

    ysyx_23060111_rf_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut4 (
        .clk(clk), .rst_n(n4_rst_n),
        .wen(n4_wen), .waddr(n4_waddr), .wdata(n4_wdata),
        .iss_en(n4_iss_en), .iss_addr(n4_iss_addr), .iss_busy(n4_iss_busy),
        .raddr1(n4_raddr1), .raddr2(n4_raddr2),
        .rdata1(n4_rdata1), .rdata2(n4_rdata2),
        .rbusy1(n4_rbusy1), .rbusy2(n4_rbusy2),
        .busy_cnt(n4_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: architectural register contents and pending set.
    logic [31:0] m_rf [32];
    logic        m_pend [32];
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[i]   = 32'h0;
                m_pend[i] = 1'b0;
            end
            model_valid = 1'b1;
        end else begin
            if (wen && waddr != 5'd0) begin
                m_rf[waddr]   = wdata;
                m_pend[waddr] = 1'b0;
            end
            if (iss_en && iss_addr != 5'd0) begin
                m_pend[iss_addr] = 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef YSYX_23060111_RF_BYPASS_EN
        if (wen && waddr != 5'd0 && a == waddr) return wdata;
`endif
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef YSYX_23060111_RF_BYPASS_EN
        if (wen && waddr != 5'd0 && a == waddr) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    function automatic logic [5:0] exp_count();
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_pend[i]) n++;
        end
        return 6'(n);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("cmp_rdata1", 64'(rdata1), 64'(exp_data(raddr1)));
            checkOutput("cmp_rdata2", 64'(rdata2), 64'(exp_data(raddr2)));
            checkOutput("cmp_rbusy1", 64'(rbusy1), 64'(exp_busy(raddr1)));
            checkOutput("cmp_rbusy2", 64'(rbusy2), 64'(exp_busy(raddr2)));
            checkOutput("cmp_iss_busy", 64'(iss_busy), 64'(exp_busy(iss_addr)));
            checkOutput("cmp_busy_cnt", 64'(busy_cnt), 64'(exp_count()));
        end
    end

    task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic ie, input logic [4:0] ia,
                                 input logic [4:0] r1, input logic [4:0] r2);
        wen      = w;
        waddr    = wa;
        wdata    = wd;
        iss_en   = ie;
        iss_addr = ia;
        raddr1   = r1;
        raddr2   = r2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        n4_rst_n = 1'b0;
        n4_wen = 1'b0; n4_waddr = 4'd0; n4_wdata = 8'h0;
        n4_iss_en = 1'b0; n4_iss_addr = 4'd0; n4_raddr1 = 4'd0; n4_raddr2 = 4'd0;

        // Junk before reset, then a reset cycle carrying a write and issue.
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 5'(i + 3), 32'hBAD0_0000 + 32'(i), 1'b1, 5'(i + 3), 5'd0, 5'd0);
            step();
        end
        rst_n = 1'b0;
        applyStimulus(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd4, 5'd4, 5'd5);
        step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd4, 5'd5);
        @(negedge clk);
        checkOutput("rst_rdata1", 64'(rdata1), 64'h0);
        checkOutput("rst_rbusy1", 64'(rbusy1), 64'h0);
        checkOutput("rst_iss_busy", 64'(iss_busy), 64'h0);
        checkOutput("rst_busy_cnt", 64'(busy_cnt), 64'h0);
        step();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(i), 5'(31 - i));
            step();
        end

        // Issue x5, then write it back.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0);
        @(negedge clk);
        checkOutput("iss5_pre_rbusy1", 64'(rbusy1), 64'h0);
        step();
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd5, 5'd5, 5'd0);
        @(negedge clk);
        checkOutput("iss5_busy_cnt", 64'(busy_cnt), 64'h1);
`ifdef YSYX_23060111_RF_BYPASS_EN
        checkOutput("wb5_byp_rdata1", 64'(rdata1), 64'hDEAD_BEEF);
        checkOutput("wb5_byp_rbusy1", 64'(rbusy1), 64'h0);
`else
        checkOutput("wb5_cur_rdata1", 64'(rdata1), 64'h0);
        checkOutput("wb5_cur_rbusy1", 64'(rbusy1), 64'h1);
`endif
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        @(negedge clk);
        checkOutput("wb5_rdata1", 64'(rdata1), 64'hDEAD_BEEF);
        checkOutput("wb5_rbusy1", 64'(rbusy1), 64'h0);
        checkOutput("wb5_busy_cnt", 64'(busy_cnt), 64'h0);
        step();

        // Index 0 accesses are dropped.
        applyStimulus(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("x0_iss_busy", 64'(iss_busy), 64'h0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("x0_rdata1", 64'(rdata1), 64'h0);
        checkOutput("x0_rbusy1", 64'(rbusy1), 64'h0);
        checkOutput("x0_busy_cnt", 64'(busy_cnt), 64'h0);
        step();

        // Same-index collision on x7: set wins, data still written.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
        step();
        applyStimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 5'd7, 5'd0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7, 5'd0);
        @(negedge clk);
        checkOutput("same_rdata1", 64'(rdata1), 64'hA5A5_A5A5);
        checkOutput("same_rbusy1", 64'(rbusy1), 64'h1);
        checkOutput("same_busy_cnt", 64'(busy_cnt), 64'h1);
        step();

        // Different-index collision: issue x9 while x3 writes back.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd9);
        step();
        applyStimulus(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd9, 5'd3, 5'd9);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9);
        @(negedge clk);
        checkOutput("diff_rbusy3", 64'(rbusy1), 64'h0);
        checkOutput("diff_rbusy9", 64'(rbusy2), 64'h1);
        checkOutput("diff_busy_cnt", 64'(busy_cnt), 64'h2);
        step();
        applyStimulus(1'b1, 5'd7, 32'h7777_7777, 1'b0, 5'd0, 5'd7, 5'd9);
        step();
        applyStimulus(1'b1, 5'd9, 32'h9999_9999, 1'b0, 5'd0, 5'd7, 5'd9);
        step();

        // Fill every register, then drain.
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(i), 5'(32 - i));
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd31, 5'd31, 5'd1);
        @(negedge clk);
        checkOutput("fill_busy_cnt", 64'(busy_cnt), 64'd31);
        checkOutput("fill_iss_busy", 64'(iss_busy), 64'h1);
        step();
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'hC000_0000 + 32'(i), 1'b0, 5'(i), 5'(i), 5'(i - 1));
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd0);
        @(negedge clk);
        checkOutput("drain_busy_cnt", 64'(busy_cnt), 64'd0);
        checkOutput("drain_rdata31", 64'(rdata1), 64'hC000_001F);
        step();

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            applyStimulus(1'($urandom_range(0, 1)), pick(), $urandom,
                          1'($urandom_range(0, 1)), pick(), pick(), pick());
            step();
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();

        // ADDR_WIDTH=4 instance: peak count is 15.
        n4_rst_n = 1'b1;
        for (int i = 1; i < 16; i++) begin
            n4_iss_en = 1'b1; n4_iss_addr = 4'(i);
            step();
        end
        n4_iss_en = 1'b0; n4_iss_addr = 4'd0; n4_raddr1 = 4'd15; n4_raddr2 = 4'd0;
        @(negedge clk);
        checkOutput("n4_fill_busy_cnt", 64'(n4_busy_cnt), 64'd15);
        checkOutput("n4_fill_rbusy15", 64'(n4_rbusy1), 64'h1);
        checkOutput("n4_fill_rbusy0", 64'(n4_rbusy2), 64'h0);
        step();
        for (int i = 1; i < 16; i++) begin
            n4_wen = 1'b1; n4_waddr = 4'(i); n4_wdata = 8'(i + 16);
            step();
        end
        n4_wen = 1'b0; n4_waddr = 4'd0;
        @(negedge clk);
        checkOutput("n4_drain_busy_cnt", 64'(n4_busy_cnt), 64'd0);
        checkOutput("n4_drain_rdata15", 64'(n4_rdata1), 64'h1F);
        checkOutput("n4_drain_rbusy15", 64'(n4_rbusy1), 64'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
